backup_sd_sync: RTL and testbench

Parametrised backup-RAM ↔ SD-image sector sequencer for the console cores. Sits between the core's nvram dual-port RAM and user_io's SD sector interface. On image mount it loads up to SECTORS 512-byte sectors; on an explicit save request, or an optional idle-timed autosave, it writes them back. It also tracks a dirty flag and issues a core-reset pulse after a completed load.

---
 rtl/backup_pkg.sv | 18 +
 rtl/backup_idle_timer.sv | 44 ++++
 rtl/backup_sd_sync.sv | 234 +++++++++++++++++++++++
 tb/tb_backup_sd_sync.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backup_pkg.sv
// Shared types and constants for the backup-RAM <-> SD-image sector sequencer.
package backup_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned SECTOR_SHIFT = 9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER
    } state_t;

    typedef enum logic {
        OP_LOAD,
        OP_SAVE
    } op_t;

endpackage

// File: rtl/backup_idle_timer.sv
// Idle timer for autosave: counts enabled ticks and pulses expire on the
// TICKS-th one, then restarts from zero.
// Ports:
//   clk_sys, reset : clock, synchronous active-high reset
//   tick           : timebase pulse
//   clear          : restart the count (takes priority over tick)
//   enable         : ticks are only counted while high
//   expire         : one-cycle registered pulse when the count is reached
module backup_idle_timer #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic tick,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = $clog2(TICKS + 1);

    logic [CW-1:0] cnt_q;

    // The count never passes TICKS-1: reaching the limit restarts it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q  <= '0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (enable && tick) begin
                if (cnt_q == CW'(TICKS - 1)) begin
                    cnt_q  <= '0;
                    expire <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/backup_sd_sync.sv
// Backup-RAM <-> SD-image sector sequencer. Loads the image into nvram on
// mount, writes it back on save request or idle autosave, tracks a dirty flag
// and pulses load_done after a complete load.
// Ports:
//   clk_sys, reset      : clock, synchronous active-high reset
//   img_mounted,img_size: mount strobe (rising edge) and image size in bytes
//   download            : ROM download (rising edge disables backup)
//   save_req            : manual save (rising edge)
//   nv_we, tick         : nvram write seen, autosave timebase
//   sd_ack              : SD sector handshake acknowledge
//   sd_lba, sd_rd, sd_wr: SD sector request
//   bk_ena, busy, dirty : status
//   load_done           : one-cycle pulse after a full load
module backup_sd_sync
    import backup_pkg::*;
#(
    parameter int unsigned SECTORS        = 16,
    parameter int unsigned LBA_BASE       = 0,
    parameter int unsigned AUTOSAVE_TICKS = 0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    input  logic        download,
    input  logic        save_req,
    input  logic        nv_we,
    input  logic        tick,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        busy,
    output logic        dirty,
    output logic        load_done
);

    localparam int unsigned CNT_W = $clog2(SECTORS + 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   n_q, n_d, idx_q, idx_d, load_n_q, load_n_d;
    logic [31:0]        lba_q, lba_d;
    logic               rd_q, rd_d, wr_q, wr_d, bk_q, bk_d, busy_q, busy_d;
    logic               dirty_q, dirty_d, done_q, done_d;
    logic               lpend_q, lpend_d, spend_q, spend_d, abort_q, abort_d;
    logic               mnt_q, dl_q, save_q, ack_q;
    logic               mnt_rise, dl_rise, save_rise, ack_rise, ack_fall;
    logic               dirty_clr, timer_expire;
    logic [32:0]        size_up;
    logic [23:0]        mnt_secs;
    logic [CNT_W-1:0]   mnt_n;

    assign mnt_rise  = img_mounted & ~mnt_q;
    assign dl_rise   = download & ~dl_q;
    assign save_rise = save_req & ~save_q;
    assign ack_rise  = sd_ack & ~ack_q;
    assign ack_fall  = ~sd_ack & ack_q;

    // Sectors to load: ceil(img_size/512) clipped to the RAM size.
    assign size_up  = {1'b0, img_size} + 33'(SECTOR_BYTES - 1);
    assign mnt_secs = 24'(size_up >> SECTOR_SHIFT);
    assign mnt_n    = (mnt_secs >= 24'(SECTORS)) ? CNT_W'(SECTORS) : CNT_W'(mnt_secs);

    generate
        if (AUTOSAVE_TICKS != 0) begin : g_autosave
            backup_idle_timer #(
                .TICKS (AUTOSAVE_TICKS)
            ) u_idle_timer (
                .clk_sys (clk_sys),
                .reset   (reset),
                .tick    (tick),
                .clear   (nv_we),
                .enable  (dirty_q && !busy_q),
                .expire  (timer_expire)
            );
        end else begin : g_no_autosave
            logic unused_tick;
            assign unused_tick  = tick;
            assign timer_expire = 1'b0;
        end
    endgenerate

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_LOAD;
            n_q      <= '0;
            idx_q    <= '0;
            load_n_q <= '0;
            lba_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            bk_q     <= 1'b0;
            busy_q   <= 1'b0;
            dirty_q  <= 1'b0;
            done_q   <= 1'b0;
            lpend_q  <= 1'b0;
            spend_q  <= 1'b0;
            abort_q  <= 1'b0;
            mnt_q    <= 1'b0;
            dl_q     <= 1'b0;
            save_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            load_n_q <= load_n_d;
            lba_q    <= lba_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            bk_q     <= bk_d;
            busy_q   <= busy_d;
            dirty_q  <= dirty_d;
            done_q   <= done_d;
            lpend_q  <= lpend_d;
            spend_q  <= spend_d;
            abort_q  <= abort_d;
            mnt_q    <= img_mounted;
            dl_q     <= download;
            save_q   <= save_req;
            ack_q    <= sd_ack;
        end
    end

    // Next-state logic: sequencer first, then events, so a fresh request in
    // the dispatch cycle is not lost when the serviced flag is cleared.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        n_d       = n_q;
        idx_d     = idx_q;
        load_n_d  = load_n_q;
        lba_d     = lba_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        bk_d      = bk_q;
        lpend_d   = lpend_q;
        spend_d   = spend_q;
        abort_d   = abort_q;
        done_d    = 1'b0;
        dirty_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (bk_q && !dl_rise && (lpend_q || spend_q)) begin
                    if (lpend_q) begin
                        op_d    = OP_LOAD;
                        n_d     = load_n_q;
                        lpend_d = 1'b0;
                        rd_d    = 1'b1;
                    end else begin
                        op_d      = OP_SAVE;
                        n_d       = CNT_W'(SECTORS);
                        spend_d   = 1'b0;
                        wr_d      = 1'b1;
                        dirty_clr = 1'b1;
                    end
                    idx_d   = '0;
                    lba_d   = 32'(LBA_BASE);
                    abort_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    // An abort lets the current handshake finish, then stops.
                    if (abort_q || dl_rise || ((idx_q + CNT_W'(1)) == n_q)) begin
                        state_d = IDLE;
                        if (op_q == OP_LOAD && !abort_q && !dl_rise) begin
                            done_d    = 1'b1;
                            dirty_clr = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        lba_d   = lba_q + 32'd1;
                        rd_d    = (op_q == OP_LOAD);
                        wr_d    = (op_q == OP_SAVE);
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase

        if (mnt_rise && (img_size != 32'd0)) begin
            bk_d     = 1'b1;
            lpend_d  = 1'b1;
            load_n_d = mnt_n;
        end
        // Save requests only mean something with an image mounted.
        if ((save_rise || timer_expire) && bk_d) begin
            spend_d = 1'b1;
        end
        if (dl_rise) begin
            bk_d    = 1'b0;
            lpend_d = 1'b0;
            spend_d = 1'b0;
            if (state_q != IDLE) begin
                abort_d = 1'b1;
            end
        end

        dirty_d = dirty_clr ? 1'b0 : dirty_q;
        if (nv_we) begin
            dirty_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    assign sd_lba    = lba_q;
    assign sd_rd     = rd_q;
    assign sd_wr     = wr_q;
    assign bk_ena    = bk_q;
    assign busy      = busy_q;
    assign dirty     = dirty_q;
    assign load_done = done_q;

endmodule

// File: tb/tb_backup_sd_sync.sv
// Directed bench for backup_sd_sync with a scoreboard of expected SD sector
// requests and a simple SD host that acknowledges each request.
module tb_backup_sd_sync;

    logic        clk_sys = 1'b0;
    logic        reset, img_mounted, download, save_req, nv_we, tick, sd_ack;
    logic [31:0] img_size, sd_lba;
    logic        sd_rd, sd_wr, bk_ena, busy, dirty, load_done;

    always #5 clk_sys = ~clk_sys;

    backup_sd_sync #(
        .SECTORS        (16),
        .LBA_BASE       (0),
        .AUTOSAVE_TICKS (3)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .download    (download),
        .save_req    (save_req),
        .nv_we       (nv_we),
        .tick        (tick),
        .sd_ack      (sd_ack),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .bk_ena      (bk_ena),
        .busy        (busy),
        .dirty       (dirty),
        .load_done   (load_done)
    );

    typedef struct {
        logic        wr;
        logic [31:0] lba;
        logic        first;
    } xact_t;

    xact_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    ld_cnt      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic push_op(input logic wr, input int n);
        xact_t x;
        for (int i = 0; i < n; i++) begin
            x.wr    = wr;
            x.lba   = 32'(i);
            x.first = (i == 0);
            sb.push_back(x);
        end
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int c = 0;
        while (!busy && c < budget) begin
            @(negedge clk_sys);
            c++;
        end
        chk(tag, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            @(negedge clk_sys);
            c++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic mount(input logic [31:0] sz);
        img_size    = sz;
        img_mounted = 1'b1;
        cyc(1);
        img_mounted = 1'b0;
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        cyc(1);
        save_req = 1'b0;
    endtask

    task automatic pulse_we();
        nv_we = 1'b1;
        cyc(1);
        nv_we = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(2);
        end
    endtask

    // SD host: sees a request, acks one cycle later, holds ack two cycles.
    initial begin : host
        int          wait_c, hold_c, since_drop;
        logic [31:0] cur_lba;
        xact_t       x;
        wait_c = 0; hold_c = 0; since_drop = 0; cur_lba = '0;
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (sd_ack) begin
                hold_c++;
                if (hold_c == 1) begin
                    chk("req_drop", 32'(sd_rd | sd_wr), 32'd0);
                    chk("lba_stable", sd_lba, cur_lba);
                end else begin
                    sd_ack     = 1'b0;
                    hold_c     = 0;
                    since_drop = 0;
                end
            end else if (sd_rd || sd_wr) begin
                if (wait_c == 0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_req", 32'(sb.size()), 32'd1);
                    end else begin
                        x = sb.pop_front();
                        chk("req_wr", 32'(sd_wr), 32'(x.wr));
                        chk("req_rd", 32'(sd_rd), 32'(!x.wr));
                        chk("req_lba", sd_lba, x.lba);
                        if (!x.first) chk("reissue_gap", 32'(since_drop), 32'd0);
                    end
                    cur_lba = sd_lba;
                end
                wait_c++;
                if (wait_c >= 2) begin
                    sd_ack = 1'b1;
                    wait_c = 0;
                end
            end else begin
                since_drop++;
                wait_c = 0;
            end
        end
    end

    initial begin : ld_mon
        forever begin
            @(negedge clk_sys);
            if (load_done) begin
                ld_cnt++;
                chk("load_done_with_idle", 32'(busy), 32'd0);
            end
        end
    end

    initial begin : stim
        int c;
        reset = 1'b1; img_mounted = 1'b0; img_size = '0; download = 1'b0;
        save_req = 1'b0; nv_we = 1'b0; tick = 1'b0;
        cyc(3);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_rd", 32'(sd_rd), 32'd0);
        chk("rst_wr", 32'(sd_wr), 32'd0);
        chk("rst_bk", 32'(bk_ena), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Full 16-sector load
        push_op(1'b0, 16);
        mount(32'd8192);
        wait_busy("t1_start", 10);
        wait_idle("t1_end", 400);
        cyc(2);
        chk("t1_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("t1_bk", 32'(bk_ena), 32'd1);
        chk("t1_dirty", 32'(dirty), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        chk("t1_last_lba", sd_lba, 32'd15);

        // Short image: 2 sectors, then a manual save of all 16
        push_op(1'b0, 2);
        mount(32'd1000);
        wait_busy("t2_start", 10);
        wait_idle("t2_end", 400);
        cyc(2);
        chk("t2_ld_cnt", 32'(ld_cnt), 32'd2);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_last_lba", sd_lba, 32'd1);
        push_op(1'b1, 16);
        pulse_save();
        wait_busy("t2_save_start", 10);
        wait_idle("t2_save_end", 400);
        cyc(2);
        chk("t2_save_ld_cnt", 32'(ld_cnt), 32'd2);
        chk("t2_save_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_save_dirty", 32'(dirty), 32'd0);

        // Save requested during a load runs after it; write during save keeps dirty
        pulse_we();
        cyc(1);
        chk("t3_dirty_set", 32'(dirty), 32'd1);
        push_op(1'b0, 16);
        push_op(1'b1, 16);
        mount(32'd8192);
        wait_busy("t3_load_start", 10);
        cyc(5);
        pulse_save();
        chk("t3_busy_during_load", 32'(busy), 32'd1);
        wait_idle("t3_load_end", 400);
        chk("t3_dirty_after_load", 32'(dirty), 32'd0);
        wait_busy("t3_save_start", 5);
        cyc(10);
        pulse_we();
        wait_idle("t3_save_end", 400);
        cyc(2);
        chk("t3_dirty_kept", 32'(dirty), 32'd1);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_ld_cnt", 32'(ld_cnt), 32'd3);

        // Autosave after 3 idle ticks; a write restarts the count
        pulse_we();
        tick_n(2);
        pulse_we();
        tick_n(2);
        cyc(5);
        chk("t4_no_early_save", 32'(busy), 32'd0);
        push_op(1'b1, 16);
        tick_n(1);
        wait_busy("t4_autosave_start", 10);
        wait_idle("t4_autosave_end", 400);
        cyc(2);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        chk("t4_dirty", 32'(dirty), 32'd0);

        // Download during sector 5 of a load
        push_op(1'b0, 6);
        mount(32'd8192);
        c = 0;
        while (!(sd_rd && sd_lba == 32'd5) && c < 400) begin
            @(negedge clk_sys);
            c++;
        end
        chk("t5_sector5_seen", 32'(sd_rd && sd_lba == 32'd5), 32'd1);
        download = 1'b1;
        cyc(1);
        wait_idle("t5_abort_end", 100);
        cyc(2);
        chk("t5_ld_cnt", 32'(ld_cnt), 32'd3);
        chk("t5_bk", 32'(bk_ena), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        download = 1'b0;
        cyc(2);
        pulse_save();
        cyc(40);
        chk("t5_save_ignored", 32'(busy), 32'd0);

        // Zero-size mount does nothing
        mount(32'd0);
        cyc(20);
        chk("t6_bk_zero", 32'(bk_ena), 32'd0);
        chk("t6_busy_zero", 32'(busy), 32'd0);

        // Reset in the middle of a transfer
        push_op(1'b0, 2);
        mount(32'd8192);
        c = 0;
        while (!(sd_ack && !sd_rd && busy && sd_lba == 32'd1) && c < 200) begin
            @(negedge clk_sys);
            c++;
        end
        chk("t6_xfer_seen", 32'(sd_ack && !sd_rd && busy && sd_lba == 32'd1), 32'd1);
        reset = 1'b1;
        cyc(1);
        chk("t6_rst_rd", 32'(sd_rd), 32'd0);
        chk("t6_rst_wr", 32'(sd_wr), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_bk", 32'(bk_ena), 32'd0);
        cyc(4);
        reset = 1'b0;
        cyc(10);
        chk("t6_post_busy", 32'(busy), 32'd0);
        chk("t6_post_rd", 32'(sd_rd), 32'd0);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
